// File: rtl/pc_bpred.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit saturating counters.
// EX-stage resolution redirects the PC and raises flush on a mispredict.
module pc_bpred #(
  parameter int unsigned            WORD_W      = 32,
  parameter logic [WORD_W-1:0]      PC_INIT     = '0,
  parameter int unsigned            BTB_ENTRIES = 16,
  parameter int unsigned            CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              stall,
  input  logic              halt,
  output logic [WORD_W-1:0] cpc,
  output logic [WORD_W-1:0] pc_plus,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_ctl,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [WORD_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [WORD_W-1:0] ex_pred_target,
  output logic              flush,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned      IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned      TAG_W = WORD_W - IDX_W - 2;
  localparam logic [WORD_W-1:0] FOUR = WORD_W'(4);

  logic [WORD_W-1:0]      cpc_q, cpc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [WORD_W-1:0]      target_q [BTB_ENTRIES];
  logic [WORD_W-1:0]      target_d [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              rd_hit, wr_hit;
  logic              ctl_mis;
  logic [WORD_W-1:0] redirect_pc;

  // Lookup on cpc reads registered state only, so a same-cycle update is not visible.
  always_comb begin
    rd_idx      = cpc_q[IDX_W+1:2];
    rd_tag      = cpc_q[WORD_W-1:IDX_W+2];
    rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pc_plus     = cpc_q + FOUR;
    pred_taken  = rd_hit && ctr_q[rd_idx][1];
    pred_target = target_q[rd_idx];
    cpc         = cpc_q;
  end

  always_comb begin
    ctl_mis     = (ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_target != ex_pred_target));
    flush       = ex_valid && (ex_is_ctl ? ctl_mis : ex_pred_taken);
    redirect_pc = (ex_is_ctl && ex_taken) ? ex_target : (ex_pc + FOUR);
    mispred_cnt = cnt_q;
  end

  always_comb begin
    cpc_d = cpc_q;
    if (halt)       cpc_d = cpc_q;
    else if (flush) cpc_d = redirect_pc;
    else if (stall) cpc_d = cpc_q;
    else if (ihit)  cpc_d = pred_taken ? pred_target : pc_plus;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    wr_idx   = ex_pc[IDX_W+1:2];
    wr_tag   = ex_pc[WORD_W-1:IDX_W+2];
    wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (ex_valid && !halt) begin
      if (ex_is_ctl) begin
        if (wr_hit) begin
          if (ex_taken) begin
            if (ctr_q[wr_idx] != 2'b11) ctr_d[wr_idx] = ctr_q[wr_idx] + 2'd1;
            target_d[wr_idx] = ex_target;
          end else if (ctr_q[wr_idx] != 2'b00) begin
            ctr_d[wr_idx] = ctr_q[wr_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_d[wr_idx]  = 1'b1;
          tag_d[wr_idx]    = wr_tag;
          target_d[wr_idx] = ex_target;
          ctr_d[wr_idx]    = 2'b10;
        end
      end else if (ex_pred_taken) begin
        // A non-control instruction predicted taken means the entry aliased; drop it.
        valid_d[wr_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cpc_q   <= PC_INIT;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      cpc_q    <= cpc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_pc_bpred.sv
// Directed bench for pc_bpred: fetch sequencing, BTB training, flush/redirect
// priority, alias invalidation, PC wrap and mispredict counter saturation.
module tb_pc_bpred;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;

  logic              CLK = 1'b0;
  logic              RST, ihit, stall, halt;
  logic [WORD_W-1:0] cpc, pc_plus, pred_target;
  logic              pred_taken;
  logic              ex_valid, ex_is_ctl, ex_taken, ex_pred_taken;
  logic [WORD_W-1:0] ex_pc, ex_target, ex_pred_target;
  logic              flush;
  logic [CNT_W-1:0]  mispred_cnt;

  int checks   = 0;
  int failures = 0;

  pc_bpred #(
    .WORD_W      (WORD_W),
    .PC_INIT     (32'h0),
    .BTB_ENTRIES (16),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .stall          (stall),
    .halt           (halt),
    .cpc            (cpc),
    .pc_plus        (pc_plus),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_ctl      (ex_is_ctl),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_ctl = 0; ex_pc = '0; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic set_ex(input logic ctl, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1; ex_is_ctl = ctl; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    RST = 1; ihit = 1; stall = 0; halt = 0; clear_ex();
    step(); step();
    checks++; if (cpc !== 32'h0) begin failures++; $display("FAIL reset_cpc got %h want %h", cpc, 32'h0); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got %b want 0", pred_taken); end
    checks++; if (mispred_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got %0d want 0", mispred_cnt); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got %b want 0", flush); end
    RST = 0;
    step();
    checks++; if (cpc !== 32'h4) begin failures++; $display("FAIL seq_4 got %h want %h", cpc, 32'h4); end
    step();
    checks++; if (cpc !== 32'h8) begin failures++; $display("FAIL seq_8 got %h want %h", cpc, 32'h8); end
    step();
    checks++; if (cpc !== 32'hC) begin failures++; $display("FAIL seq_C got %h want %h", cpc, 32'hC); end
    checks++; if (pc_plus !== 32'h10) begin failures++; $display("FAIL pc_plus_C got %h want %h", pc_plus, 32'h10); end
  endtask

  task automatic test_loop();
    step();
    checks++; if (cpc !== 32'h10) begin failures++; $display("FAIL loop_cpc10 got %h want %h", cpc, 32'h10); end
    ihit = 0;
    set_ex(1, 32'h10, 1, 32'h4, 0, 32'h0);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL loop_flush got %b want 1", flush); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL loop_nobypass got %b want 0", pred_taken); end
    step();
    checks++; if (cpc !== 32'h4) begin failures++; $display("FAIL loop_redirect got %h want %h", cpc, 32'h4); end
    checks++; if (mispred_cnt !== 8'd1) begin failures++; $display("FAIL loop_cnt got %0d want 1", mispred_cnt); end
    clear_ex(); ihit = 1;
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL loop_noflush got %b want 0", flush); end
    step(); step(); step();
    ihit = 0;
    checks++; if (cpc !== 32'h10) begin failures++; $display("FAIL loop_refetch got %h want %h", cpc, 32'h10); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL loop_pred got %b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h4) begin failures++; $display("FAIL loop_ptgt got %h want %h", pred_target, 32'h4); end
  endtask

  task automatic test_counter();
    ihit = 0;
    set_ex(1, 32'h10, 1, 32'h4, 1, 32'h4);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL ctr_taken_flush[%0d] got %b want 0", i, flush); end
      step();
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL ctr_taken_pred[%0d] got %b want 1", i, pred_taken); end
    end
    ex_taken = 0;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ctr_nt_flush got %b want 1", flush); end
    step();
    checks++; if (cpc !== 32'h14) begin failures++; $display("FAIL ctr_nt_cpc got %h want %h", cpc, 32'h14); end
    checks++; if (mispred_cnt !== 8'd2) begin failures++; $display("FAIL ctr_cnt got %0d want 2", mispred_cnt); end
    clear_ex();
  endtask

  task automatic test_redirect_priority();
    ihit = 0; stall = 1;
    set_ex(1, 32'h30, 1, 32'h10, 0, 32'h0);
    step();
    checks++; if (cpc !== 32'h10) begin failures++; $display("FAIL stall_redirect got %h want %h", cpc, 32'h10); end
    checks++; if (mispred_cnt !== 8'd3) begin failures++; $display("FAIL stall_cnt got %0d want 3", mispred_cnt); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL ctr10_pred got %b want 1", pred_taken); end
    halt = 1;
    set_ex(1, 32'h10, 0, 32'h0, 1, 32'h4);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL halt_flush got %b want 1", flush); end
    step();
    checks++; if (cpc !== 32'h10) begin failures++; $display("FAIL halt_hold got %h want %h", cpc, 32'h10); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL halt_nowrite got %b want 1", pred_taken); end
    checks++; if (mispred_cnt !== 8'd4) begin failures++; $display("FAIL halt_cnt got %0d want 4", mispred_cnt); end
    halt = 0;
    step();
    checks++; if (cpc !== 32'h14) begin failures++; $display("FAIL nt2_cpc got %h want %h", cpc, 32'h14); end
    set_ex(1, 32'h30, 1, 32'h10, 1, 32'h20);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL tgt_mis_flush got %b want 1", flush); end
    step();
    checks++; if (cpc !== 32'h10) begin failures++; $display("FAIL tgt_mis_cpc got %h want %h", cpc, 32'h10); end
    checks++; if (mispred_cnt !== 8'd6) begin failures++; $display("FAIL tgt_mis_cnt got %0d want 6", mispred_cnt); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ctr01_pred got %b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h4) begin failures++; $display("FAIL ctr01_ptgt got %h want %h", pred_target, 32'h4); end
    clear_ex(); stall = 0;
  endtask

  task automatic test_alias();
    ihit = 0;
    set_ex(1, 32'h10, 1, 32'h4, 0, 32'h0);
    step();
    checks++; if (cpc !== 32'h4) begin failures++; $display("FAIL retrain_cpc got %h want %h", cpc, 32'h4); end
    clear_ex(); ihit = 1;
    step(); step(); step();
    ihit = 0;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL retrain_pred got %b want 1", pred_taken); end
    set_ex(0, 32'h50, 0, 32'h0, 1, 32'h4);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL alias_flush got %b want 1", flush); end
    step();
    checks++; if (cpc !== 32'h54) begin failures++; $display("FAIL alias_cpc got %h want %h", cpc, 32'h54); end
    checks++; if (mispred_cnt !== 8'd8) begin failures++; $display("FAIL alias_cnt got %0d want 8", mispred_cnt); end
    set_ex(1, 32'h30, 1, 32'h10, 0, 32'h0);
    step();
    checks++; if (cpc !== 32'h10) begin failures++; $display("FAIL alias_back got %h want %h", cpc, 32'h10); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_inval got %b want 0", pred_taken); end
    set_ex(1, 32'h40, 1, 32'hFFFF_FFFC, 0, 32'h0);
    step();
    clear_ex();
    #1;
    checks++; if (cpc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_cpc got %h want %h", cpc, 32'hFFFF_FFFC); end
    checks++; if (pc_plus !== 32'h0) begin failures++; $display("FAIL wrap_plus got %h want %h", pc_plus, 32'h0); end
    checks++; if (mispred_cnt !== 8'd10) begin failures++; $display("FAIL wrap_cnt got %0d want 10", mispred_cnt); end
    ihit = 1;
    step();
    ihit = 0;
    checks++; if (cpc !== 32'h0) begin failures++; $display("FAIL wrap_next got %h want %h", cpc, 32'h0); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL wrap_tagmiss got %b want 0", pred_taken); end
  endtask

  task automatic test_saturate();
    halt = 1;
    set_ex(0, 32'h8, 0, 32'h0, 1, 32'h0);
    for (int i = 0; i < 259; i++) begin
      step();
      if (i == 244) begin
        checks++; if (mispred_cnt !== 8'hFF) begin failures++; $display("FAIL sat_reach got %0d want 255", mispred_cnt); end
      end
    end
    checks++; if (mispred_cnt !== 8'hFF) begin failures++; $display("FAIL sat_hold got %0d want 255", mispred_cnt); end
    checks++; if (cpc !== 32'h0) begin failures++; $display("FAIL sat_halt_cpc got %h want %h", cpc, 32'h0); end
    halt = 0;
    set_ex(1, 32'h8, 1, 32'h80, 0, 32'h0);
    RST = 1;
    step();
    checks++; if (cpc !== 32'h0) begin failures++; $display("FAIL rst_wins_cpc got %h want %h", cpc, 32'h0); end
    checks++; if (mispred_cnt !== 8'd0) begin failures++; $display("FAIL rst_wins_cnt got %0d want 0", mispred_cnt); end
    RST = 0; clear_ex();
  endtask

  initial begin
    test_reset();
    test_loop();
    test_counter();
    test_redirect_priority();
    test_alias();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
